// File: rtl/load_writeback_unit_if.sv
// Read port between the write-back unit and the variable-latency data memory.
// Handshake: the unit holds Mem_Rd_Req high with a stable Mem_Addr until the
// memory answers with a single-cycle Mem_Rd_Ack; Mem_Rd_Data is valid only
// in that ack cycle. An ack while Mem_Rd_Req is low carries no meaning.
interface load_writeback_unit_if #(
    parameter int DWIDTH = 32
);
    logic              Mem_Rd_Req;
    logic [DWIDTH-1:0] Mem_Addr;
    logic              Mem_Rd_Ack;
    logic [DWIDTH-1:0] Mem_Rd_Data;

    modport master (
        output Mem_Rd_Req,
        output Mem_Addr,
        input  Mem_Rd_Ack,
        input  Mem_Rd_Data
    );

    modport slave (
        input  Mem_Rd_Req,
        input  Mem_Addr,
        output Mem_Rd_Ack,
        output Mem_Rd_Data
    );
endinterface

// File: rtl/load_writeback_unit.sv
// Write-back stage feeding the register file write port. Non-load results are
// written in the same cycle; loads run IDLE -> REQ -> WB against data memory,
// stalling fetch until the extended load value is written.
module load_writeback_unit #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              N_Rst,
    input  logic              Instr_Valid,
    input  logic              Reg_Write,
    input  logic [1:0]        Result_Src,
    input  logic [2:0]        Funct3,
    input  logic [AWIDTH-1:0] Rd,
    input  logic [DWIDTH-1:0] ALU_Result,
    input  logic [DWIDTH-1:0] PC_Plus4,
    input  logic [DWIDTH-1:0] Imm_Ext,
    load_writeback_unit_if.master mem,
    output logic              Stall,
    output logic              WE3,
    output logic [AWIDTH-1:0] WA3,
    output logic [DWIDTH-1:0] WD3,
    output logic              Load_Fault,
    output logic [1:0]        Fault_Cause,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WB = 2'd2} state_t;

    localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] rd_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [DWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic [CW-1:0]     cnt_q;
    logic              fault_q;
    logic [1:0]        cause_q;

    logic              is_load, illegal_f3, misaligned, start_load, timeout;
    logic              fault_det;
    logic [1:0]        cause_det;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DWIDTH-1:0] load_ext;
    logic              rd_req;
    logic [DWIDTH-1:0] rd_addr;

    // Load decode and fault detection for the instruction presented in IDLE.
    always_comb begin
        is_load    = Instr_Valid && (Result_Src == 2'b01);
        illegal_f3 = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11);
        misaligned = ((Funct3[1:0] == 2'b01) && ALU_Result[0]) ||
                     ((Funct3 == 3'b010) && (ALU_Result[1:0] != 2'b00));
        start_load = (state == IDLE) && is_load && !illegal_f3 && !misaligned;
        timeout    = (state == REQ) && !mem.Mem_Rd_Ack && (cnt_q == CNT_LAST);
        fault_det  = 1'b0;
        cause_det  = 2'b00;
        if ((state == IDLE) && is_load && illegal_f3) begin
            fault_det = 1'b1;
            cause_det = 2'b10;
        end else if ((state == IDLE) && is_load && misaligned) begin
            fault_det = 1'b1;
            cause_det = 2'b01;
        end else if (timeout) begin
            fault_det = 1'b1;
            cause_det = 2'b11;
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_load) state_nxt = REQ;
            REQ:     if (mem.Mem_Rd_Ack) state_nxt = WB;
                     else if (timeout)   state_nxt = IDLE;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Load context capture, ack wait counter and registered fault report.
    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            rd_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            if (start_load) begin
                rd_q   <= Rd;
                we_q   <= Reg_Write;
                f3_q   <= Funct3;
                addr_q <= ALU_Result;
                cnt_q  <= '0;
            end else if (state == REQ) begin
                if (mem.Mem_Rd_Ack) data_q <= mem.Mem_Rd_Data;
                else                cnt_q  <= cnt_q + 1'b1;
            end
            fault_q <= fault_det;
            cause_q <= cause_det;
        end
    end

    // Byte/half selection and sign/zero extension of the captured word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = data_q[7:0];
            2'd1:    byte_sel = data_q[15:8];
            2'd2:    byte_sel = data_q[23:16];
            default: byte_sel = data_q[31:24];
        endcase
        half_sel = addr_q[1] ? data_q[31:16] : data_q[15:0];
        case (f3_q)
            3'b000:  load_ext = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {{(DWIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_ext = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_ext = {{(DWIDTH-16){1'b0}}, half_sel};
            default: load_ext = data_q;
        endcase
    end

    // Outputs per state; everything is forced low while reset is asserted.
    always_comb begin
        rd_req      = 1'b0;
        rd_addr     = '0;
        Stall       = 1'b0;
        WE3         = 1'b0;
        WA3         = '0;
        WD3         = '0;
        Load_Fault  = 1'b0;
        Fault_Cause = 2'b00;
        dbg_state   = 2'b00;
        if (N_Rst) begin
            Load_Fault  = fault_q;
            Fault_Cause = cause_q;
            dbg_state   = state;
            case (state)
                IDLE: begin
                    Stall = start_load;
                    if (Instr_Valid && Reg_Write && (Rd != '0) && (Result_Src != 2'b01)) begin
                        WE3 = 1'b1;
                        WA3 = Rd;
                        case (Result_Src)
                            2'b10:   WD3 = PC_Plus4;
                            2'b11:   WD3 = Imm_Ext;
                            default: WD3 = ALU_Result;
                        endcase
                    end
                end
                REQ: begin
                    rd_req  = 1'b1;
                    rd_addr = {addr_q[DWIDTH-1:2], 2'b00};
                    Stall   = 1'b1;
                end
                WB: begin
                    WE3 = we_q && (rd_q != '0);
                    WA3 = rd_q;
                    WD3 = load_ext;
                end
                default: ;
            endcase
        end
    end

    assign mem.Mem_Rd_Req = rd_req;
    assign mem.Mem_Addr   = rd_addr;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed bench for load_writeback_unit: same-cycle ALU/PC+4/immediate
// writes, byte/half/word loads with varying ack latency, load faults, ack
// timeout and reset during an outstanding request.
module tb_load_writeback_unit;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk;
    logic          N_Rst;
    logic          Instr_Valid;
    logic          Reg_Write;
    logic [1:0]    Result_Src;
    logic [2:0]    Funct3;
    logic [AW-1:0] Rd;
    logic [DW-1:0] ALU_Result;
    logic [DW-1:0] PC_Plus4;
    logic [DW-1:0] Imm_Ext;
    logic          Stall;
    logic          WE3;
    logic [AW-1:0] WA3;
    logic [DW-1:0] WD3;
    logic          Load_Fault;
    logic [1:0]    Fault_Cause;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    load_writeback_unit_if #(.DWIDTH(DW)) mem_bus ();

    load_writeback_unit #(.DWIDTH(DW), .AWIDTH(AW), .ACK_TIMEOUT(16)) dut (
        .Clk         (Clk),
        .N_Rst       (N_Rst),
        .Instr_Valid (Instr_Valid),
        .Reg_Write   (Reg_Write),
        .Result_Src  (Result_Src),
        .Funct3      (Funct3),
        .Rd          (Rd),
        .ALU_Result  (ALU_Result),
        .PC_Plus4    (PC_Plus4),
        .Imm_Ext     (Imm_Ext),
        .mem         (mem_bus.master),
        .Stall       (Stall),
        .WE3         (WE3),
        .WA3         (WA3),
        .WD3         (WD3),
        .Load_Fault  (Load_Fault),
        .Fault_Cause (Fault_Cause),
        .dbg_state   (dbg_state)
    );

    // Clock: 10 time-unit period, active edge at posedge.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one cycle; inputs change and outputs are sampled 1-2 units after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Instr_Valid = 1'b0;
        Reg_Write   = 1'b0;
        Result_Src  = 2'b00;
        Funct3      = 3'b000;
        Rd          = '0;
        ALU_Result  = '0;
        mem_bus.Mem_Rd_Ack  = 1'b0;
        mem_bus.Mem_Rd_Data = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        PC_Plus4 = 32'h0000_0104;
        Imm_Ext  = 32'hABCD_E000;
        N_Rst    = 1'b0;
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Rd = 5'd5; ALU_Result = 32'h1234;
        #2;
        total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL rst_we3: got %b expected 0", WE3); end
        total++; if (WD3 !== 32'h0) begin bad++; $display("FAIL rst_wd3: got %h expected 0", WD3); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b expected 0", Stall); end
        total++; if (mem_bus.Mem_Rd_Req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", mem_bus.Mem_Rd_Req); end
        total++; if (Load_Fault !== 1'b0) begin bad++; $display("FAIL rst_fault: got %b expected 0", Load_Fault); end
        tick(); tick();
        idle_inputs();
        N_Rst = 1'b1;
        #1;
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        tick();
    endtask

    task automatic test_alu_ops();
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Result_Src = 2'b00; Rd = 5'd5; ALU_Result = 32'h0000_1234;
        #1;
        total++; if (WE3 !== 1'b1) begin bad++; $display("FAIL alu_we3: got %b expected 1", WE3); end
        total++; if (WA3 !== 5'd5) begin bad++; $display("FAIL alu_wa3: got %0d expected 5", WA3); end
        total++; if (WD3 !== 32'h0000_1234) begin bad++; $display("FAIL alu_wd3: got %h expected 00001234", WD3); end
        total++; if (Stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b expected 0", Stall); end
        tick();
        Rd = 5'd0;
        #1;
        total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL alu_rd0_we3: got %b expected 0", WE3); end
        tick();
        Rd = 5'd1; Result_Src = 2'b10;
        #1;
        total++; if (WD3 !== 32'h0000_0104 || WE3 !== 1'b1) begin bad++; $display("FAIL pc4_wd3: got %h/%b expected 00000104/1", WD3, WE3); end
        tick();
        Rd = 5'd31; Result_Src = 2'b11;
        #1;
        total++; if (WD3 !== 32'hABCD_E000 || WA3 !== 5'd31) begin bad++; $display("FAIL imm_wd3: got %h/%0d expected abcde000/31", WD3, WA3); end
        tick();
        Reg_Write = 1'b0; Result_Src = 2'b00; Rd = 5'd6;
        #1;
        total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL noregwrite_we3: got %b expected 0", WE3); end
        tick();
        idle_inputs();
    endtask

    // One complete load: detect cycle, ack_cycle REQ cycles, one WB cycle.
    // A non-load instruction is held on the inputs during REQ and must be ignored.
    task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] data, input int ack_cycle, input logic [31:0] exp);
        int stalls;
        stalls = 0;
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Result_Src = 2'b01; Funct3 = f3; Rd = rd; ALU_Result = addr;
        #1;
        if (Stall === 1'b1) stalls++;
        total++; if (mem_bus.Mem_Rd_Req !== 1'b0 || WE3 !== 1'b0) begin bad++; $display("FAIL ld_detect f3=%0d: req/we3 got %b/%b expected 0/0", f3, mem_bus.Mem_Rd_Req, WE3); end
        tick();
        Result_Src = 2'b00; Rd = 5'd3; ALU_Result = 32'h5555_5555;
        for (int k = 1; k <= ack_cycle; k++) begin
            mem_bus.Mem_Rd_Ack  = (k == ack_cycle);
            mem_bus.Mem_Rd_Data = (k == ack_cycle) ? data : 32'hDEAD_BEEF;
            #1;
            if (Stall === 1'b1) stalls++;
            total++; if (mem_bus.Mem_Rd_Req !== 1'b1 || mem_bus.Mem_Addr !== (addr & 32'hFFFF_FFFC) || WE3 !== 1'b0)
                begin bad++; $display("FAIL ld_req f3=%0d cyc=%0d: req/addr/we3 got %b/%h/%b expected 1/%h/0", f3, k, mem_bus.Mem_Rd_Req, mem_bus.Mem_Addr, WE3, addr & 32'hFFFF_FFFC); end
            tick();
        end
        idle_inputs();
        #1;
        if (Stall === 1'b1) stalls++;
        total++; if (WE3 !== 1'b1 || WA3 !== rd || WD3 !== exp)
            begin bad++; $display("FAIL ld_wb f3=%0d: we3/wa3/wd3 got %b/%0d/%h expected 1/%0d/%h", f3, WE3, WA3, WD3, rd, exp); end
        total++; if (mem_bus.Mem_Rd_Req !== 1'b0) begin bad++; $display("FAIL ld_wb_req f3=%0d: got %b expected 0", f3, mem_bus.Mem_Rd_Req); end
        total++; if (stalls != 1 + ack_cycle) begin bad++; $display("FAIL ld_stall_cycles f3=%0d: got %0d expected %0d", f3, stalls, 1 + ack_cycle); end
        tick();
        #1;
        total++; if (dbg_state !== 2'd0 || Load_Fault !== 1'b0) begin bad++; $display("FAIL ld_done f3=%0d: state/fault got %0d/%b expected 0/0", f3, dbg_state, Load_Fault); end
    endtask

    task automatic test_byte_loads();
        run_load(3'b000, 32'h0000_0103, 5'd10, 32'h80FF_0000, 3, 32'hFFFF_FF80);
        run_load(3'b100, 32'h0000_0103, 5'd11, 32'h80FF_0000, 1, 32'h0000_0080);
        run_load(3'b000, 32'h0000_0101, 5'd12, 32'h1234_5678, 2, 32'h0000_0056);
        run_load(3'b000, 32'h0000_0100, 5'd13, 32'h1234_56F0, 1, 32'hFFFF_FFF0);
    endtask

    task automatic test_half_word_loads();
        run_load(3'b001, 32'h0000_0202, 5'd14, 32'h8001_1234, 2, 32'hFFFF_8001);
        run_load(3'b101, 32'h0000_0202, 5'd15, 32'h8001_1234, 1, 32'h0000_8001);
        run_load(3'b001, 32'h0000_0200, 5'd16, 32'h8001_9234, 1, 32'hFFFF_9234);
        run_load(3'b010, 32'h0000_0204, 5'd17, 32'h8001_1234, 1, 32'h8001_1234);
    endtask

    task automatic test_back_to_back();
        run_load(3'b010, 32'h0000_0208, 5'd18, 32'h0BAD_F00D, 1, 32'h0BAD_F00D);
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Result_Src = 2'b00; Rd = 5'd19; ALU_Result = 32'h0000_0777;
        #0.5;
        total++; if (WE3 !== 1'b1 || WA3 !== 5'd19 || WD3 !== 32'h777) begin bad++; $display("FAIL b2b_alu: we3/wa3/wd3 got %b/%0d/%h expected 1/19/00000777", WE3, WA3, WD3); end
        tick();
        run_load(3'b100, 32'h0000_020A, 5'd20, 32'h00C3_0000, 1, 32'h0000_00C3);
    endtask

    // Fault case: check the detect cycle, then the registered pulse, then its clearing.
    task automatic fault_case(input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] cause);
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Result_Src = 2'b01; Funct3 = f3; Rd = 5'd8; ALU_Result = addr;
        #1;
        total++; if (mem_bus.Mem_Rd_Req !== 1'b0 || WE3 !== 1'b0 || Stall !== 1'b0 || Load_Fault !== 1'b0)
            begin bad++; $display("FAIL flt_detect f3=%0d addr=%h: req/we3/stall/fault got %b/%b/%b/%b expected 0/0/0/0", f3, addr, mem_bus.Mem_Rd_Req, WE3, Stall, Load_Fault); end
        tick();
        idle_inputs();
        #1;
        total++; if (Load_Fault !== 1'b1 || Fault_Cause !== cause || dbg_state !== 2'd0)
            begin bad++; $display("FAIL flt_pulse f3=%0d addr=%h: fault/cause/state got %b/%b/%0d expected 1/%b/0", f3, addr, Load_Fault, Fault_Cause, dbg_state, cause); end
        tick();
        #1;
        total++; if (Load_Fault !== 1'b0 || Fault_Cause !== 2'b00) begin bad++; $display("FAIL flt_clear f3=%0d: fault/cause got %b/%b expected 0/00", f3, Load_Fault, Fault_Cause); end
        tick();
    endtask

    task automatic test_faults();
        fault_case(3'b010, 32'h0000_0206, 2'b01);
        fault_case(3'b001, 32'h0000_0201, 2'b01);
        fault_case(3'b101, 32'h0000_0203, 2'b01);
        fault_case(3'b011, 32'h0000_0200, 2'b10);
        fault_case(3'b111, 32'h0000_0203, 2'b10);
        fault_case(3'b110, 32'h0000_0200, 2'b10);
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Result_Src = 2'b01; Funct3 = 3'b010; Rd = 5'd21; ALU_Result = 32'h0000_0300;
        tick();
        idle_inputs();
        while (n < 40) begin
            #1;
            if (mem_bus.Mem_Rd_Req !== 1'b1) break;
            n++;
            if (WE3 !== 1'b0) begin total++; bad++; $display("FAIL to_we3: got %b expected 0", WE3); end
            tick();
        end
        total++; if (n != 16) begin bad++; $display("FAIL to_req_cycles: got %0d expected 16", n); end
        total++; if (Load_Fault !== 1'b1 || Fault_Cause !== 2'b11 || dbg_state !== 2'd0)
            begin bad++; $display("FAIL to_fault: fault/cause/state got %b/%b/%0d expected 1/11/0", Load_Fault, Fault_Cause, dbg_state); end
        mem_bus.Mem_Rd_Ack = 1'b1; mem_bus.Mem_Rd_Data = 32'h1111_2222;
        #1;
        total++; if (mem_bus.Mem_Rd_Req !== 1'b0 || WE3 !== 1'b0) begin bad++; $display("FAIL to_late_ack: req/we3 got %b/%b expected 0/0", mem_bus.Mem_Rd_Req, WE3); end
        tick();
        mem_bus.Mem_Rd_Ack = 1'b0;
        #1;
        total++; if (dbg_state !== 2'd0 || WE3 !== 1'b0 || Load_Fault !== 1'b0) begin bad++; $display("FAIL to_after: state/we3/fault got %0d/%b/%b expected 0/0/0", dbg_state, WE3, Load_Fault); end
        tick();
    endtask

    task automatic test_reset_mid_req();
        Instr_Valid = 1'b1; Reg_Write = 1'b1; Result_Src = 2'b01; Funct3 = 3'b010; Rd = 5'd22; ALU_Result = 32'h0000_0400;
        tick();
        idle_inputs();
        #1;
        total++; if (mem_bus.Mem_Rd_Req !== 1'b1 || Stall !== 1'b1) begin bad++; $display("FAIL mr_req: req/stall got %b/%b expected 1/1", mem_bus.Mem_Rd_Req, Stall); end
        #1;
        N_Rst = 1'b0;
        #1;
        total++; if (mem_bus.Mem_Rd_Req !== 1'b0 || Stall !== 1'b0 || WE3 !== 1'b0)
            begin bad++; $display("FAIL mr_drop: req/stall/we3 got %b/%b/%b expected 0/0/0", mem_bus.Mem_Rd_Req, Stall, WE3); end
        mem_bus.Mem_Rd_Ack = 1'b1; mem_bus.Mem_Rd_Data = 32'h3333_4444;
        tick();
        #3;
        N_Rst = 1'b1;
        mem_bus.Mem_Rd_Ack = 1'b0;
        tick();
        #0.5;
        total++; if (WE3 !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL mr_after: we3/state got %b/%0d expected 0/0", WE3, dbg_state); end
        tick();
        run_load(3'b010, 32'h0000_0404, 5'd9, 32'hCAFE_BABE, 1, 32'hCAFE_BABE);
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_alu_ops();
        test_byte_loads();
        test_half_word_loads();
        test_back_to_back();
        test_faults();
        test_timeout();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
